// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK frame symbol path: symbol address width,
// default address constants and the frame generator state encoding.
package fsk_pkg;

    localparam int SYM_AW = 5;

    localparam logic [SYM_AW-1:0] IDLE_ADDR_DEF = 5'd0;
    localparam logic [SYM_AW-1:0] PRE_A_DEF     = 5'd0;
    localparam logic [SYM_AW-1:0] PRE_B_DEF     = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

endpackage

// File: rtl/frame_sym_gen.sv
// Frame symbol generator: walks IDLE -> PREAMBLE -> SYNC -> PAYLOAD -> GAP
// one symbol per READY strobe and emits a registered LUT address. Payload
// symbols are taken from the external LFSR, which is stepped by PRN_ADV.
module frame_sym_gen
    import fsk_pkg::*;
#(
    parameter int                PREAMBLE_LEN = 16,
    parameter logic [19:0]       SYNC_WORD    = 20'h08864,
    parameter int                PAYLOAD_LEN  = 64,
    parameter int                GAP_LEN      = 8,
    parameter logic [SYM_AW-1:0] IDLE_ADDR    = IDLE_ADDR_DEF,
    parameter logic [SYM_AW-1:0] PRE_A        = PRE_A_DEF,
    parameter logic [SYM_AW-1:0] PRE_B        = PRE_B_DEF
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              READY,
    input  logic [SYM_AW-1:0] PRN_IN,
    output logic [SYM_AW-1:0] ADDRESS,
    output logic              PRN_ADV,
    output logic              FRAME_ACTIVE,
    output logic              FRAME_DONE
);

    localparam logic [7:0] PRE_LEN_C = 8'(PREAMBLE_LEN);
    localparam logic [7:0] PAY_LEN_C = 8'(PAYLOAD_LEN);
    localparam logic [7:0] GAP_LEN_C = 8'(GAP_LEN);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [SYM_AW-1:0] addr_q, addr_d;
    logic              adv_q, adv_d;
    logic              act_q, act_d;
    logic              done_q, done_d;

    // Sync chunk k (1..3) of the sync word; chunk 0 is emitted on PREAMBLE exit.
    function automatic logic [SYM_AW-1:0] sync_chunk(input logic [7:0] k);
        case (k)
            8'd1:    return SYNC_WORD[14:10];
            8'd2:    return SYNC_WORD[9:5];
            default: return SYNC_WORD[4:0];
        endcase
    endfunction

    // Next-state logic: everything advances only on a READY strobe; the
    // PRN_ADV and FRAME_DONE pulses default low so they last one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        adv_d   = 1'b0;
        done_d  = 1'b0;
        if (READY) begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (state_q == ST_GAP && cnt_q != GAP_LEN_C) begin
                        addr_d = IDLE_ADDR;
                        cnt_d  = cnt_q + 8'd1;
                    end else begin
                        // End of GAP behaves exactly like IDLE on the same
                        // edge so back-to-back frames have no dead strobe.
                        done_d = (state_q == ST_GAP);
                        if (ENABLE) begin
                            addr_d  = PRE_A;
                            cnt_d   = 8'd1;
                            state_d = ST_PREAMBLE;
                        end else begin
                            addr_d  = IDLE_ADDR;
                            cnt_d   = 8'd0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (cnt_q == PRE_LEN_C) begin
                        addr_d  = SYNC_WORD[19:15];
                        cnt_d   = 8'd1;
                        state_d = ST_SYNC;
                    end else begin
                        addr_d = cnt_q[0] ? PRE_B : PRE_A;
                        cnt_d  = cnt_q + 8'd1;
                    end
                end
                ST_SYNC: begin
                    if (cnt_q == 8'd4) begin
                        addr_d  = PRN_IN;
                        adv_d   = 1'b1;
                        cnt_d   = 8'd1;
                        state_d = ST_PAYLOAD;
                    end else begin
                        addr_d = sync_chunk(cnt_q);
                        cnt_d  = cnt_q + 8'd1;
                    end
                end
                ST_PAYLOAD: begin
                    if (cnt_q == PAY_LEN_C) begin
                        addr_d  = IDLE_ADDR;
                        cnt_d   = 8'd1;
                        state_d = ST_GAP;
                    end else begin
                        addr_d = PRN_IN;
                        adv_d  = 1'b1;
                        cnt_d  = cnt_q + 8'd1;
                    end
                end
                default: begin
                    addr_d  = IDLE_ADDR;
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end
            endcase
        end
        act_d = (state_d == ST_PREAMBLE) || (state_d == ST_SYNC) ||
                (state_d == ST_PAYLOAD);
    end

    // State and output registers; reset overrides any strobe on the same edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= IDLE_ADDR;
            adv_q   <= 1'b0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            adv_q   <= adv_d;
            act_q   <= act_d;
            done_q  <= done_d;
        end
    end

    assign ADDRESS      = addr_q;
    assign PRN_ADV      = adv_q;
    assign FRAME_ACTIVE = act_q;
    assign FRAME_DONE   = done_q;

endmodule

// File: tb/tb_frame_sym_gen.sv
// Bench for frame_sym_gen: directed READY/ENABLE/RESET scenarios, a
// frame-position model checked every cycle, and literal sequence checks.
module tb_frame_sym_gen;

    localparam int PL  = 4;
    localparam int PAY = 3;
    localparam int GL  = 2;
    localparam int FL  = PL + 4 + PAY + GL;
    localparam logic [19:0] SW = 20'h08864;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       ENABLE = 1'b0;
    logic       READY = 1'b0;
    logic [4:0] PRN_IN = 5'd7;
    logic [4:0] ADDRESS;
    logic       PRN_ADV, FRAME_ACTIVE, FRAME_DONE;

    int checks = 0;
    int errors = 0;
    int n_adv = 0;
    int n_done = 0;
    logic chk_en = 1'b0;

    frame_sym_gen #(
        .PREAMBLE_LEN(PL), .SYNC_WORD(SW), .PAYLOAD_LEN(PAY), .GAP_LEN(GL),
        .IDLE_ADDR(5'd0), .PRE_A(5'd0), .PRE_B(5'd16)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .READY(READY),
        .PRN_IN(PRN_IN), .ADDRESS(ADDRESS), .PRN_ADV(PRN_ADV),
        .FRAME_ACTIVE(FRAME_ACTIVE), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLOCK = ~CLOCK;

    // Stand-in LFSR: a counter stepped by each PRN_ADV pulse.
    always @(posedge CLOCK) if (PRN_ADV) PRN_IN <= PRN_IN + 5'd1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Model: pos is the index of the next symbol within a frame (-1 = idle,
    // FL = gap finished). Symbol value is a pure function of position.
    int   pos = -1;
    int   m_prn = 7;
    int   e_addr = 0;
    logic e_adv = 0, e_act = 0, e_done = 0;

    always @(posedge CLOCK) begin
        if (RESET) begin
            pos = -1; e_addr = 0; e_adv = 0; e_act = 0; e_done = 0;
        end else begin
            e_adv = 0; e_done = 0;
            if (READY) begin
                if (pos < 0 || pos == FL) begin
                    e_done = (pos == FL);
                    if (ENABLE) begin e_addr = 0; e_act = 1; pos = 1; end
                    else begin e_addr = 0; e_act = 0; pos = -1; end
                end else begin
                    if (pos < PL) e_addr = (pos % 2) ? 16 : 0;
                    else if (pos < PL + 4) e_addr = int'((SW >> (5 * (3 - (pos - PL)))) & 20'h1f);
                    else if (pos < PL + 4 + PAY) begin
                        e_addr = m_prn; m_prn = (m_prn + 1) % 32; e_adv = 1;
                    end else e_addr = 0;
                    e_act = (pos < PL + 4 + PAY);
                    pos++;
                end
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge CLOCK) begin
        if (chk_en) begin
            chk("ADDRESS", int'(ADDRESS), e_addr);
            chk("PRN_ADV", int'(PRN_ADV), int'(e_adv));
            chk("FRAME_ACTIVE", int'(FRAME_ACTIVE), int'(e_act));
            chk("FRAME_DONE", int'(FRAME_DONE), int'(e_done));
            if (PRN_ADV) n_adv++;
            if (FRAME_DONE) n_done++;
        end
    end

    // One READY strobe followed by gap-1 idle cycles; returns the address
    // and FRAME_DONE seen right after the strobe edge.
    task automatic strobe(input int gap, output logic [4:0] a, output logic d);
        READY = 1'b1;
        @(posedge CLOCK); #1;
        READY = 1'b0;
        a = ADDRESS;
        d = FRAME_DONE;
        repeat (gap - 1) @(posedge CLOCK);
        #1;
    endtask

    task automatic run(input int n);
        logic [4:0] a; logic d;
        for (int i = 0; i < n; i++) strobe(4, a, d);
    endtask

    initial begin
        logic [4:0] a; logic d;
        logic [4:0] seq[$];
        int exp1[13] = '{0, 16, 0, 16, 1, 2, 3, 4, 7, 8, 9, 0, 0};
        int exp_rs[5] = '{0, 16, 0, 16, 1};
        int done_idx[$];
        int adv0, done0;
        logic [4:0] p0;

        repeat (3) @(posedge CLOCK);
        #1;
        chk_en = 1'b1;
        chk("reset_ADDRESS", int'(ADDRESS), 0);
        chk("reset_ACTIVE", int'(FRAME_ACTIVE), 0);
        RESET = 1'b0;

        // ENABLE low throughout
        adv0 = n_adv; done0 = n_done;
        run(20);
        chk("idle_adv_count", n_adv - adv0, 0);
        chk("idle_done_count", n_done - done0, 0);
        chk("idle_ADDRESS", int'(ADDRESS), 0);

        // Single frame
        adv0 = n_adv; done0 = n_done;
        ENABLE = 1'b1; strobe(4, a, d); seq.push_back(a);
        ENABLE = 1'b0;
        for (int i = 0; i < 12; i++) begin strobe(4, a, d); seq.push_back(a); end
        for (int i = 0; i < 13; i++) chk($sformatf("single_seq[%0d]", i), int'(seq[i]), exp1[i]);
        run(2);
        chk("single_adv_count", n_adv - adv0, 3);
        chk("single_done_count", n_done - done0, 1);
        chk("single_end_ACTIVE", int'(FRAME_ACTIVE), 0);

        // Back-to-back frames
        ENABLE = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            strobe(4, a, d);
            if (d) begin
                done_idx.push_back(i);
                chk("b2b_preA_on_done", int'(a), 0);
            end
        end
        chk("b2b_done_count", done_idx.size(), 2);
        if (done_idx.size() == 2) begin
            chk("b2b_first_done", done_idx[0], 14);
            chk("b2b_period", done_idx[1] - done_idx[0], FL);
        end
        ENABLE = 1'b0;
        run(12);

        // READY stall inside SYNC
        ENABLE = 1'b1; strobe(4, a, d); ENABLE = 1'b0;
        run(4);
        p0 = PRN_IN;
        adv0 = n_adv;
        for (int k = 0; k < 4; k++) begin
            strobe(11, a, d);
            chk("stall_hold", int'(ADDRESS), int'(a));
            chk($sformatf("stall_sym[%0d]", k), int'(a), (k < 3) ? (k + 2) : int'(p0));
            chk($sformatf("stall_adv[%0d]", k), n_adv - adv0, (k < 3) ? 0 : 1);
        end
        run(6);

        // Reset in PAYLOAD after the second payload symbol
        ENABLE = 1'b1; strobe(4, a, d); ENABLE = 1'b0;
        run(9);
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        chk("rst_pay_ADDRESS", int'(ADDRESS), 0);
        chk("rst_pay_ACTIVE", int'(FRAME_ACTIVE), 0);
        seq.delete();
        ENABLE = 1'b1; strobe(4, a, d); seq.push_back(a); ENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin strobe(4, a, d); seq.push_back(a); end
        for (int i = 0; i < 5; i++) chk($sformatf("restart_seq[%0d]", i), int'(seq[i]), exp_rs[i]);
        run(9);

        // RESET and READY together in PREAMBLE
        ENABLE = 1'b1; strobe(4, a, d);
        RESET = 1'b1; READY = 1'b1;
        @(posedge CLOCK); #1;
        RESET = 1'b0; READY = 1'b0; ENABLE = 1'b0;
        chk("rst_rdy_ADDRESS", int'(ADDRESS), 0);
        chk("rst_rdy_ACTIVE", int'(FRAME_ACTIVE), 0);
        repeat (3) @(posedge CLOCK); #1;
        run(3);
        chk("rst_rdy_idle_ACTIVE", int'(FRAME_ACTIVE), 0);
        ENABLE = 1'b1; strobe(4, a, d); ENABLE = 1'b0;
        chk("rst_rdy_restart0", int'(a), 0);
        strobe(4, a, d);
        chk("rst_rdy_restart1", int'(a), 16);
        run(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_sym_gen.md
FRAME_SYM_GEN -- requirements
Module: frame_sym_gen

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- PREAMBLE_LEN, 16: preamble symbols (1..255).
- SYNC_WORD, 20'h08864: four 5-bit sync addresses, MSB chunk first.
- PAYLOAD_LEN, 64: PRN payload symbols (1..255).
- GAP_LEN, 8: idle symbols after each frame (1..255).
- IDLE_ADDR, 5'd0: address emitted in IDLE and GAP.
- PRE_A, 5'd0: preamble even-symbol address.
- PRE_B, 5'd16: preamble odd-symbol address.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLOCK, input, 1: single system clock, 16 MHz; all logic on posedge.
- RESET, input, 1: synchronous, active-high reset.
- ENABLE, input, 1: level; permits frame start and frame repeat.
- READY, input, 1: one-cycle symbol strobe from the sample clock generator.
- PRN_IN, input, 5: LFSR output bits [18:14].
- ADDRESS, output, 5: registered symbol address to the symbol LUT.
- PRN_ADV, output, 1: one-cycle pulse; drives LFSR ENABLE.
- FRAME_ACTIVE, output, 1: high in PREAMBLE, SYNC and PAYLOAD.
- FRAME_DONE, output, 1: one-cycle pulse at end of GAP.

Function
REQ-003 The block SHALL implement FSM states IDLE, PREAMBLE, SYNC, PAYLOAD and GAP, with an 8-bit symbol counter CNT.
REQ-004 State, CNT and ADDRESS SHALL change only on a clock edge where READY=1; READY=0 holds all of them.
REQ-005 ADDRESS SHALL update on the READY edge and be visible the following cycle, a latency of 1 cycle.
REQ-006 IDLE: ADDRESS=IDLE_ADDR; READY with ENABLE=1 SHALL emit PRE_A, set CNT=1 and enter PREAMBLE.
REQ-007 PREAMBLE: each READY SHALL emit PRE_A if CNT is even and PRE_B if CNT is odd, then increment CNT.
REQ-008 PREAMBLE: the READY arriving with CNT=PREAMBLE_LEN SHALL instead emit SYNC_WORD[19:15], set CNT=1 and enter SYNC.
REQ-009 SYNC: READY with CNT=k (k=1..3) SHALL emit chunk k (bits [19-5k:15-5k]).
REQ-010 SYNC: READY with CNT=4 SHALL emit PRN_IN, pulse PRN_ADV, set CNT=1 and enter PAYLOAD.
REQ-011 PAYLOAD: READY with CNT<PAYLOAD_LEN SHALL emit PRN_IN, pulse PRN_ADV and increment CNT.
REQ-012 PAYLOAD: READY with CNT=PAYLOAD_LEN SHALL emit IDLE_ADDR, set CNT=1 and enter GAP.
REQ-013 PRN_ADV SHALL be high for exactly the one cycle after each edge that loads PRN_IN into ADDRESS, so each payload symbol consumes one new PRN word.
REQ-014 GAP: READY with CNT<GAP_LEN SHALL emit IDLE_ADDR and increment CNT.
REQ-015 GAP: READY with CNT=GAP_LEN SHALL pulse FRAME_DONE for one cycle and behave as IDLE on the same edge (ENABLE=1: emit PRE_A, enter PREAMBLE; ENABLE=0: enter IDLE).
REQ-016 ENABLE deasserted mid-frame SHALL NOT abort the frame; the frame and its GAP SHALL complete.
REQ-017 FRAME_ACTIVE SHALL be a registered output reflecting the state entered on the last edge.
REQ-018 Each frame SHALL be exactly PREAMBLE_LEN+4+PAYLOAD_LEN+GAP_LEN READY strobes long.

Reset
REQ-019 RESET=1 SHALL take priority over READY and ENABLE on the same edge.
REQ-020 RESET SHALL force state=IDLE, CNT=0, ADDRESS=IDLE_ADDR, PRN_ADV=0, FRAME_ACTIVE=0 and FRAME_DONE=0 on the next edge.
REQ-021 RESET mid-frame SHALL discard the frame; the first READY after release with ENABLE=1 SHALL start a new preamble with PRE_A.

Structure
REQ-022 A shared package fsk_pkg SHALL hold the state enum, SYM_AW=5 and the default IDLE_ADDR, PRE_A and PRE_B constants.
REQ-023 The block SHALL be a single module with no sub-module; the LFSR and the symbol LUT stay external.

Verification
REQ-024 Parameters for all scenarios: PREAMBLE_LEN=4, PAYLOAD_LEN=3, GAP_LEN=2, SYNC_WORD=20'h08864, READY every 4 cycles, PRN_IN incremented by the bench on each PRN_ADV starting at 5'd7.
REQ-025 The bench SHALL cover these scenarios:
- Single frame: ENABLE high then low after the first READY -> ADDRESS sequence 0,16,0,16,1,2,3,4,7,8,9,0,0; exactly 3 PRN_ADV pulses; FRAME_DONE once; then IDLE.
- Back-to-back: ENABLE held high -> PRE_A on the same edge as FRAME_DONE; frame period of 13 READY strobes.
- READY stall: READY gaps of 10 cycles inside SYNC -> ADDRESS holds and no extra PRN_ADV.
- Reset in PAYLOAD after the second payload symbol -> next cycle ADDRESS=0 and FRAME_ACTIVE=0; restart emits 0,16,... .
- RESET and READY asserted together in PREAMBLE -> reset wins; CNT=0 and state IDLE.
- ENABLE low throughout, READY running -> ADDRESS stays 0; no PRN_ADV or FRAME_DONE.
